// File: rtl/tt_um_seven_segment_fun_if.sv
// Button pulse bus between the debounce front-end and the counter/mode core.
// Each signal is a single-cycle pulse that marks an accepted button press.
interface tt_um_seven_segment_fun_if;
    logic inc_pulse;
    logic dec_pulse;
    logic mode_pulse;
    logic clr_pulse;

    modport master (output inc_pulse, dec_pulse, mode_pulse, clr_pulse);
    modport slave  (input  inc_pulse, dec_pulse, mode_pulse, clr_pulse);
endinterface

// File: rtl/tt_um_seven_segment_fun.sv
// Tiny Tapeout top: four debounced push-buttons drive a hex counter and a chase animation
// on one 7-segment display. Define DP_HEARTBEAT_EN to blink the decimal point.

module seven_seg_buttons #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [3:0]                         btn_i,
    tt_um_seven_segment_fun_if.master          pulse_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    acc_q, acc_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    // The stability counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        acc_d   = acc_q;
        pulse_d = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    acc_d[i]   = sync2_q[i];
                    pulse_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign pulse_o.inc_pulse  = pulse_q[0];
    assign pulse_o.dec_pulse  = pulse_q[1];
    assign pulse_o.mode_pulse = pulse_q[2];
    assign pulse_o.clr_pulse  = pulse_q[3];
endmodule

module seven_seg_core (
    input  logic                      clk,
    input  logic                      rst_n,
    tt_um_seven_segment_fun_if.slave  pulse_i,
    output logic [3:0]                count_o,
    output logic                      chase_o,
    output logic                      enter_chase_o
);
    typedef enum logic {ST_COUNT = 1'b0, ST_CHASE = 1'b1} mode_e;

    mode_e      state_q, state_d;
    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (pulse_i.clr_pulse) begin
            count_d = 4'd0;
        end else if (pulse_i.inc_pulse && !pulse_i.dec_pulse) begin
            count_d = count_q + 4'd1;
        end else if (pulse_i.dec_pulse && !pulse_i.inc_pulse) begin
            count_d = count_q - 4'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        enter_chase_o = 1'b0;
        case (state_q)
            ST_COUNT: if (pulse_i.mode_pulse) begin
                state_d       = ST_CHASE;
                enter_chase_o = 1'b1;
            end
            ST_CHASE: if (pulse_i.mode_pulse) state_d = ST_COUNT;
            default:  state_d = ST_COUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COUNT;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign chase_o = (state_q == ST_CHASE);
endmodule

module tt_um_seven_segment_fun #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int ANIM_CYCLES     = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int AW = $clog2(ANIM_CYCLES + 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CYCLES - 1);

    tt_um_seven_segment_fun_if pls ();

    logic [3:0]    count;
    logic          chase;
    logic          enter_chase;
    logic [AW-1:0] anim_q, anim_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp;

    seven_seg_buttons #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_buttons (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (ui_in[3:0]),
        .pulse_o (pls)
    );

    seven_seg_core u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .pulse_i       (pls),
        .count_o       (count),
        .chase_o       (chase),
        .enter_chase_o (enter_chase)
    );

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    // The animation timer restarts on entry to CHASE so the first step lasts a full period.
    always_comb begin
        anim_d = anim_q + 1'b1;
        idx_d  = idx_q;
        if (enter_chase) begin
            anim_d = '0;
            idx_d  = 3'd0;
        end else if (anim_q == ANIM_LAST) begin
            anim_d = '0;
            if (chase) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        seg_d = chase ? (7'd1 << idx_q) : hex_glyph(count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_q <= '0;
            idx_q  <= 3'd0;
            seg_q  <= 7'h3F;
        end else begin
            anim_q <= anim_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
        end
    end

`ifdef DP_HEARTBEAT_EN
    logic [AW-1:0] hb_q;
    logic          dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q <= '0;
            dp_q <= 1'b0;
        end else if (hb_q == ANIM_LAST) begin
            hb_q <= '0;
            dp_q <= ~dp_q;
        end else begin
            hb_q <= hb_q + 1'b1;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

    assign uo_out  = {dp, seg_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_seven_segment_fun.sv
// Directed bench for the seven-segment toy: debounce, counter, chase mode and reset behaviour
// with shortened debounce/animation periods.
module tb_tt_um_seven_segment_fun;
    localparam int DB   = 16;
    localparam int ANIM = 40;
    localparam int HOLD = DB + 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    tt_um_seven_segment_fun #(.DEBOUNCE_CYCLES(DB), .ANIM_CYCLES(ANIM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask);
        @(negedge clk);
        ui_in = {4'h0, mask};
        cycles(HOLD);
        ui_in = 8'h00;
        cycles(HOLD);
    endtask

    task automatic check_seg(input string tag, input logic [6:0] exp);
        check_eq(tag, {1'b0, uo_out[6:0]}, {1'b0, exp});
`ifndef DP_HEARTBEAT_EN
        check_eq({tag, "_dp"}, {7'd0, uo_out[7]}, 8'h00);
`endif
    endtask

    logic [6:0] chase_pat [6];
    logic       found;

    initial begin
        chase_pat[0] = 7'h02; chase_pat[1] = 7'h04; chase_pat[2] = 7'h08;
        chase_pat[3] = 7'h10; chase_pat[4] = 7'h20; chase_pat[5] = 7'h01;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check_seg("reset_seg", 7'h3F);
        check_eq("reset_uio_out", uio_out, 8'h00);
        check_eq("reset_uio_oe", uio_oe, 8'h00);
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        check_seg("after_reset", 7'h3F);

        // Glitch rejection: two short pulses
        ui_in = 8'h01; cycles(DB / 2); ui_in = 8'h00; cycles(5 * DB);
        ui_in = 8'h01; cycles(DB / 2); ui_in = 8'h00; cycles(10 * DB);
        check_seg("glitch", 7'h3F);

        // Press INC then DEC
        press(4'b0001); check_seg("inc_1", 7'h06);
        press(4'b0010); check_seg("dec_0", 7'h3F);

        // Wrap around
        press(4'b0010); check_seg("dec_wrap_F", 7'h71);
        press(4'b0001); check_seg("inc_wrap_0", 7'h3F);
        for (int i = 0; i < 16; i++) press(4'b0001);
        check_seg("inc16", 7'h3F);

        // Chase mode step timing
        @(negedge clk);
        ui_in = 8'h04;
        found = 1'b0;
        for (int i = 0; i < DB + 20 && !found; i++) begin
            @(negedge clk);
            if (uo_out[6:0] == 7'h01) found = 1'b1;
        end
        check_eq("chase_enter", {7'd0, found}, 8'h01);
        cycles(ANIM - 1);
        check_seg("chase_hold_a", 7'h01);
        for (int s = 0; s < 6; s++) begin
            cycles((s == 0) ? 1 : ANIM);
            check_seg($sformatf("chase_step%0d", s + 1), chase_pat[s]);
        end
        ui_in = 8'h00;
        cycles(HOLD);

        // Counter keeps running in CHASE; second MODE shows it
        press(4'b0001);
        press(4'b0100); check_seg("mode_back", 7'h06);

        // INC with DEC together: no change
        press(4'b0011); check_seg("inc_dec_same", 7'h06);

        // Clear
        for (int i = 0; i < 4; i++) press(4'b0001);
        check_seg("count5", 7'h6D);
        press(4'b1000); check_seg("clr", 7'h3F);
        press(4'b0001); check_seg("inc_before_clr", 7'h06);
        press(4'b1001); check_seg("inc_clr_same", 7'h3F);

`ifdef DP_HEARTBEAT_EN
        begin
            logic dp0;
            dp0 = uo_out[7];
            found = 1'b0;
            for (int i = 0; i < ANIM + 5 && !found; i++) begin
                @(negedge clk);
                if (uo_out[7] != dp0) found = 1'b1;
            end
            check_eq("hb_toggle", {7'd0, found}, 8'h01);
            dp0 = uo_out[7];
            cycles(ANIM - 1);
            check_eq("hb_hold", {7'd0, uo_out[7]}, {7'd0, dp0});
            cycles(1);
            check_eq("hb_next", {7'd0, uo_out[7]}, {7'd0, ~dp0});
        end
`endif

        // Reset mid-press: one pulse after release, no auto-repeat
        press(4'b0001); check_seg("pre_reset", 7'h06);
        @(negedge clk);
        ui_in = 8'h01;
        cycles(DB / 2);
        rst_n = 1'b0;
        #1;
        check_seg("midpress_reset", 7'h3F);
        cycles(3);
        rst_n = 1'b1;
        cycles(HOLD);
        check_seg("held_after_reset", 7'h06);
        cycles(4 * DB);
        check_seg("no_repeat", 7'h06);
        ui_in = 8'h00;
        cycles(HOLD);
        check_seg("released", 7'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
